// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_lvl: sizing and parameter legality.
// Optional feature macro: SYNC_FIFO_WMARK_EN (see sync_fifo_lvl).
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // afull must be reachable and non-trivial; aempty must not cover full.
  function automatic bit th_legal(
    input int afull_th,
    input int aempty_th,
    input int depth
  );
    return (afull_th >= 1) && (afull_th <= depth)
        && (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

  function automatic bit size_legal(input int asize);
    return (asize >= 1) && (asize <= 16)
        && (clog2(fifo_depth(asize)) == asize);
  endfunction

endpackage

// File: rtl/fifomem.sv
// FIFO storage array: synchronous write, combinational read.
// Contents are never reset; only the pointers define validity.
module fifomem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with level, thresholds, FWFT mode and sticky errors.
// Define SYNC_FIFO_WMARK_EN to enable the peak-level (wmark) register.
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   level,
  output logic             ovf,
  output logic             udf,
  output logic [ASIZE:0]   wmark
);

  localparam int DEPTH = fifo_depth(ASIZE);

  localparam logic [ASIZE:0] FULL_LVL =
    {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_LVL =
    (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE_LVL =
    (ASIZE+1)'(AEMPTY_TH);

  if (!size_legal(ASIZE)) begin : g_bad_size
    $error("sync_fifo_lvl: ASIZE out of range");
  end

  if (!th_legal(AFULL_TH, AEMPTY_TH, DEPTH)) begin : g_bad_th
    $error("sync_fifo_lvl: AFULL_TH/AEMPTY_TH out of range");
  end

  logic [ASIZE:0] wptr_q;
  logic [ASIZE:0] rptr_q;
  logic [ASIZE:0] level_q;
  logic [ASIZE:0] wptr_d;
  logic [ASIZE:0] rptr_d;
  logic [ASIZE:0] level_d;

  logic full_q;
  logic empty_q;
  logic afull_q;
  logic aempty_q;
  logic ovf_q;
  logic udf_q;

  logic full_d;
  logic empty_d;
  logic afull_d;
  logic aempty_d;
  logic ovf_d;
  logic udf_d;

  logic push_ok;
  logic pop_ok;
  logic mem_we;

  logic [DSIZE-1:0] mem_rdata;

  // Every flag derives from the next-cycle level so all outputs agree.
  always_comb begin
    push_ok = winc & ~full_q;
    pop_ok  = rinc & ~empty_q;

    wptr_d = wptr_q + (ASIZE+1)'(push_ok);
    rptr_d = rptr_q + (ASIZE+1)'(pop_ok);
    ovf_d  = ovf_q | (winc & full_q);
    udf_d  = udf_q | (rinc & empty_q);

    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end

    level_d  = wptr_d - rptr_d;
    full_d   = (level_d == FULL_LVL);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AF_LVL);
    aempty_d = (level_d <= AE_LVL);
  end

  assign mem_we = push_ok & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifomem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (clr) begin
        rdata_q <= '0;
      end else if (pop_ok) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata = rdata_q;
  end

`ifdef SYNC_FIFO_WMARK_EN
  logic [ASIZE:0] wmark_q;

  // level_d is already zero on clr, but clr must also drop the peak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmark_q <= '0;
    end else if (clr) begin
      wmark_q <= '0;
    end else if (level_d > wmark_q) begin
      wmark_q <= level_d;
    end
  end

  assign wmark = wmark_q;
`else
  assign wmark = '0;
`endif

  assign wfull  = full_q;
  assign rempty = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: standard and FWFT instances on shared stimulus,
// checked against a queue-based reference model.
module tb_sync_fifo_lvl;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;

  logic [DSIZE-1:0] s_rdata;
  logic             s_wfull;
  logic             s_rempty;
  logic             s_afull;
  logic             s_aempty;
  logic [ASIZE:0]   s_level;
  logic             s_ovf;
  logic             s_udf;
  logic [ASIZE:0]   s_wmark;

  logic [DSIZE-1:0] f_rdata;
  logic             f_wfull;
  logic             f_rempty;
  logic             f_afull;
  logic             f_aempty;
  logic [ASIZE:0]   f_level;
  logic             f_ovf;
  logic             f_udf;
  logic [ASIZE:0]   f_wmark;

  sync_fifo_lvl #(
    .DSIZE(DSIZE), .ASIZE(ASIZE),
    .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .clr(clr),
    .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty),
    .afull(s_afull), .aempty(s_aempty), .level(s_level),
    .ovf(s_ovf), .udf(s_udf), .wmark(s_wmark)
  );

  sync_fifo_lvl #(
    .DSIZE(DSIZE), .ASIZE(ASIZE),
    .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)
  ) u_fw (
    .clk(clk), .rst(rst), .clr(clr),
    .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
    .afull(f_afull), .aempty(f_aempty), .level(f_level),
    .ovf(f_ovf), .udf(f_udf), .wmark(f_wmark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DSIZE-1:0] q[$];
  bit               m_ovf;
  bit               m_udf;
  logic [DSIZE-1:0] m_rd;
  int               m_wm;

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_rd  = '0;
    m_wm  = 0;
  endtask

  task automatic model_step(input bit w, input logic [DSIZE-1:0] d,
                            input bit r, input bit c);
    bit full;
    bit empty;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (c) begin
      model_reset();
    end else begin
      if (w && full) m_ovf = 1;
      if (r && empty) m_udf = 1;
      if (r && !empty) m_rd = q.pop_front();
      if (w && !full) q.push_back(d);
      if (q.size() > m_wm) m_wm = q.size();
    end
  endtask

  task automatic check_all(input string ph);
    int n;
    int wm_exp;
    n = q.size();
`ifdef SYNC_FIFO_WMARK_EN
    wm_exp = m_wm;
`else
    wm_exp = 0;
`endif
    chk({ph, ".level"}, 32'(s_level), 32'(n));
    chk({ph, ".wfull"}, 32'(s_wfull), 32'(n == DEPTH));
    chk({ph, ".rempty"}, 32'(s_rempty), 32'(n == 0));
    chk({ph, ".afull"}, 32'(s_afull), 32'(n >= AF));
    chk({ph, ".aempty"}, 32'(s_aempty), 32'(n <= AE));
    chk({ph, ".ovf"}, 32'(s_ovf), 32'(m_ovf));
    chk({ph, ".udf"}, 32'(s_udf), 32'(m_udf));
    chk({ph, ".rdata"}, 32'(s_rdata), 32'(m_rd));
    chk({ph, ".wmark"}, 32'(s_wmark), 32'(wm_exp));
    chk({ph, ".f_level"}, 32'(f_level), 32'(n));
    chk({ph, ".f_rempty"}, 32'(f_rempty), 32'(n == 0));
    if (n > 0) chk({ph, ".f_rdata"}, 32'(f_rdata), 32'(q[0]));
  endtask

  task automatic step(input string ph, input bit w,
                      input logic [DSIZE-1:0] d,
                      input bit r, input bit c);
    winc  = w;
    wdata = d;
    rinc  = r;
    clr   = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
    winc = 0;
    rinc = 0;
    clr  = 0;
    check_all(ph);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1;
    clr   = 0;
    winc  = 0;
    rinc  = 0;
    wdata = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0);
    step("push_full", 1, 8'hEE, 0, 0);
    step("both_full", 1, 8'hEF, 1, 0);
    step("refill", 1, 8'h10, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 8'h00, 1, 0);
    step("pop_empty", 0, 8'h00, 1, 0);
    step("both_empty", 1, 8'h77, 1, 0);
    step("clr_push", 1, 8'h55, 0, 1);
    step("pop_after_clr", 0, 8'h00, 1, 0);
    step("clr", 0, 8'h00, 0, 1);

    for (int i = 0; i < 8; i++) step("to8", 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step("wrap8", 1, 8'($urandom), 1, 0);

    step("clr", 0, 8'h00, 0, 1);
    step("fwft_a5", 1, 8'hA5, 0, 0);
    chk("fwft_a5.data", 32'(f_rdata), 32'h000000A5);
    step("fwft_pop", 0, 8'h00, 1, 0);
    chk("fwft_pop.empty", 32'(f_rempty), 32'd1);

    step("clr", 0, 8'h00, 0, 1);
    for (int i = 0; i < 11; i++) step("wm_up", 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 8; i++) step("wm_dn", 0, 8'h00, 1, 0);
    step("wm_clr", 0, 8'h00, 0, 1);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), 8'($urandom),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
    end

    step("clr", 0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) step("to9", 1, 8'($urandom), 0, 0);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 0;
    step("post_rst", 1, 8'h3C, 0, 0);
    step("post_rst_pop", 0, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
